multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath.
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives one phase of datapath enables per cycle.
//  Instruction and data memories use req/ready handshakes, so each access may take more than one cycle.
//  Counts retired instructions; flags illegal opcodes and memory timeouts.
// PARAMETERS
//  TIMEOUT  16  max consecutive cycles with req high and mem_ready low before a fault
//  CNT_W    32  width of retired-instruction counter
// PORTS
//  clock       input   1      rising-edge clock
//  reset       input   1      asynchronous, active-low reset
//  opcode      input   7      instruction[6:0] from instruction register
//  zero        input   1      ALU zero flag
//  mem_ready   input   1      addressed memory completes the current req this cycle
//  imem_req    output  1      instruction fetch request
//  dmem_req    output  1      data memory request
//  ir_write    output  1      latch fetched instruction
//  pc_write    output  1      load PC
//  pc_src      output  1      0 = PC+4, 1 = branch target (datapath computes it from old-PC register)
//  reg_write   output  1      register file write enable
//  mem_read    output  1      data memory read
//  mem_write   output  1      data memory write
//  alu_src     output  1      0 = rs2, 1 = immediate
//  alu_op      output  2      00 = add (ld/st), 01 = branch compare, 10 = funct-decoded
//  mem_to_reg  output  1      1 = writeback from memory
//  fault       output  1      sticky error flag
//  retired     output  CNT_W  instructions retired
//  state       output  3      current state (debug)
// BEHAVIOUR
//  Encoding: FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 HALT=5.
//  Reset low: state=FETCH; fault, retired, wait counter and all outputs 0, effective immediately (async).
//    First imem_req is in the first cycle after reset deasserts.
//    Reset mid-access drops the request; no write enable may assert during reset.
//  FETCH: imem_req=1. On mem_ready (same cycle): ir_write=1, pc_write=1, pc_src=0; next state DECODE.
//  DECODE (1 cycle): latch opcode into op_q; all later decode uses op_q.
//    Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch.
//    Legal -> EXECUTE. Illegal -> HALT with fault=1.
//  EXECUTE (1 cycle): alu_src=1 for I/load/store, else 0. alu_op=00 for ld/st, 01 for branch, 10 for R/I.
//    Branch: pc_write=zero, pc_src=1; retired+1; next FETCH.
//    Load/store: next MEMORY. R/I: next WRITEBACK.
//  MEMORY: dmem_req=1; mem_read=1 (load) or mem_write=1 (store); alu_src=1 and alu_op=00 held.
//    Stay until mem_ready. Store then retired+1 and next FETCH. Load then next WRITEBACK.
//  WRITEBACK (1 cycle): reg_write=1; mem_to_reg=1 for load, else 0; retired+1; next FETCH.
//  Timeout: wait counter clears on state entry and on mem_ready.
//    It increments each FETCH/MEMORY cycle with req high and mem_ready low.
//    When it reaches TIMEOUT-1 and ready is still low: next HALT, fault=1.
//  HALT: all outputs 0 except fault=1 and state; only reset exits HALT.
//  mem_ready with no req outstanding is ignored. retired wraps from 2^CNT_W-1 to 0.
//  CPI with zero-wait memory: branch 3, R/I 4, store 4, load 5. Each wait cycle adds 1.
// TESTING
//  1 R-type add (0110011), mem_ready always 1:
//    states 0,1,2,4,0; reg_write high only in cycle 4; alu_op=10; retired=1.
//  2 Load (0000011), data ready after 3 wait cycles:
//    MEMORY lasts 4 cycles with dmem_req/mem_read high; then WRITEBACK with mem_to_reg=1; CPI=8.
//  3 Branch, zero=1 then zero=0:
//    pc_write=1/pc_src=1 in EXECUTE of the first only; both take 3 cycles; retired=2.
//  4 Illegal opcode 1111111:
//    HALT after DECODE; fault=1; no reg_write or mem_write ever; mem_ready pulses are ignored.
//  5 TIMEOUT=16, mem_ready held 0 in FETCH:
//    HALT after exactly 16 req cycles; imem_req drops; fault stays 1 until reset.
//  6 Reset pulled low mid-MEMORY of a store:
//    mem_write=0 that cycle; state=0; retired=0; the next fetch restarts cleanly.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle sequencer for an RV32I datapath. Each instruction steps through
// FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK). One phase of datapath
// enables is driven per cycle. The sequencer counts retired instructions and
// raises a sticky fault on an illegal opcode or a memory timeout.
//
// Handshake: a request output (imem_req_o / dmem_req_o) is held high for the
// whole access. The access completes in the cycle where the request is high
// and mem_ready_i is high. mem_ready_i is ignored in any cycle with no request.
// Once raised, a request stays high until that completion or a timeout.
//
// Parameters
//   TIMEOUT  max consecutive cycles with a request high and mem_ready_i low
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   opcode_i       instruction[6:0] from the instruction register
//   zero_i         ALU zero flag (branch taken when high)
//   mem_ready_i    addressed memory completes the current request
//   imem_req_o     instruction fetch request
//   dmem_req_o     data memory request
//   ir_write_o     latch the fetched instruction
//   pc_write_o     load the PC
//   pc_src_o       0 = PC+4, 1 = branch target
//   reg_write_o    register file write enable
//   mem_read_o     data memory read
//   mem_write_o    data memory write
//   alu_src_o      0 = rs2, 1 = immediate
//   alu_op_o       00 add (ld/st), 01 branch compare, 10 funct-decoded
//   mem_to_reg_o   1 = write back from memory
//   fault_o        sticky error flag
//   retired_o      retired-instruction count (wraps)
//   state_o        current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             mem_to_reg_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  // Raw (ungated) control outputs from the next-state logic
  logic       imem_req_c, dmem_req_c, ir_write_c, pc_write_c, pc_src_c;
  logic       reg_write_c, mem_read_c, mem_write_c, alu_src_c, mem_to_reg_c;
  logic [1:0] alu_op_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      op_q      <= 7'd0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fault_d      = fault_q;
    retired_d    = retired_q;
    wait_d       = '0;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = 2'b00;
    mem_to_reg_c = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        // Legality is judged on the live opcode; everything later uses op_q.
        op_d = opcode_i;
        if (opcode_i == OP_R || opcode_i == OP_I || opcode_i == OP_LOAD ||
            opcode_i == OP_STORE || opcode_i == OP_BRANCH) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
      end

      S_EXECUTE: begin
        if (op_q == OP_R) begin
          alu_op_c = 2'b10;
          state_d  = S_WRITEBACK;
        end else if (op_q == OP_I) begin
          alu_src_c = 1'b1;
          alu_op_c  = 2'b10;
          state_d   = S_WRITEBACK;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          alu_src_c = 1'b1;
          alu_op_c  = 2'b00;
          state_d   = S_MEMORY;
        end else if (op_q == OP_BRANCH) begin
          alu_op_c   = 2'b01;
          pc_write_c = zero_i;
          pc_src_c   = 1'b1;
          retired_d  = retired_q + CNT_W'(1);
          state_d    = S_FETCH;
        end else begin
          // op_q was checked in DECODE; only a corrupted register lands here.
          state_d = S_HALT;
          fault_d = 1'b1;
        end
      end

      S_MEMORY: begin
        dmem_req_c  = 1'b1;
        alu_src_c   = 1'b1;
        alu_op_c    = 2'b00;
        mem_read_c  = (op_q == OP_LOAD);
        mem_write_c = (op_q == OP_STORE);
        if (mem_ready_i) begin
          if (op_q == OP_STORE) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WRITEBACK: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (op_q == OP_LOAD);
        retired_d    = retired_q + CNT_W'(1);
        state_d      = S_FETCH;
      end

      S_HALT: begin
        fault_d = 1'b1;
      end

      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  // Reset forces every enable low at once, including the FETCH request that
  // the reset state would otherwise drive while reset is still asserted.
  assign imem_req_o   = imem_req_c   & rst_ni;
  assign dmem_req_o   = dmem_req_c   & rst_ni;
  assign ir_write_o   = ir_write_c   & rst_ni;
  assign pc_write_o   = pc_write_c   & rst_ni;
  assign pc_src_o     = pc_src_c     & rst_ni;
  assign reg_write_o  = reg_write_c  & rst_ni;
  assign mem_read_o   = mem_read_c   & rst_ni;
  assign mem_write_o  = mem_write_c  & rst_ni;
  assign alu_src_o    = alu_src_c    & rst_ni;
  assign alu_op_o     = alu_op_c     & {2{rst_ni}};
  assign mem_to_reg_o = mem_to_reg_c & rst_ni;
  assign fault_o      = fault_q;
  assign retired_o    = retired_q;
  assign state_o      = state_q;

endmodule
